telemetry_framer: RTL and testbench

- Packetizes 32-bit telemetry words into framed byte streams and paces them into the downstream UART transmitter through its byte-plus-send-strobe interface.
- The UART transmitter exposes no full or done flag, so this block alone guarantees its input buffer never overruns, by spacing byte strobes at least one UART character time apart.
- Frame layout: sync byte, payload length, payload bytes, XOR checksum.

---
 rtl/ice_uart_pkg.sv | 15 +
 rtl/frame_byte_pacer.sv | 59 +++++
 rtl/telemetry_framer.sv | 163 ++++++++++++++++
 tb/tb_telemetry_framer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ice_uart_pkg.sv
// Shared constants and state encoding for the telemetry framer.
package ice_uart_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned IDX_W         = 8;
  localparam int unsigned LEN_W         = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOAD    = 2'd1,
    PULSE   = 2'd2,
    GAP     = 2'd3
  } fr_state_e;

endpackage

// File: rtl/frame_byte_pacer.sv
// Gap timer and tx_send pulse generator; one start per byte.
module frame_byte_pacer #(
  parameter int unsigned BYTE_GAP_CLKS  = 1529,
  parameter int unsigned SEND_HIGH_CLKS = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic tx_send,
  output logic gap_done
);

  localparam int unsigned TIMER_W = $clog2(BYTE_GAP_CLKS);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               active_q, active_d;
  logic               tx_send_q, tx_send_d;
  logic               gap_done_q, gap_done_d;

  // Timer is 0 the cycle after start; send is high while timer < SEND_HIGH_CLKS
  // (one cycle delayed), gap_done fires in the cycle the timer reads GAP-1.
  always_comb begin
    timer_d    = timer_q;
    active_d   = active_q;
    tx_send_d  = 1'b0;
    gap_done_d = 1'b0;
    if (start) begin
      timer_d  = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      tx_send_d  = (timer_q < TIMER_W'(SEND_HIGH_CLKS));
      gap_done_d = (timer_q == TIMER_W'(BYTE_GAP_CLKS - 2));
      if (timer_q == TIMER_W'(BYTE_GAP_CLKS - 1)) begin
        active_d = 1'b0;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
  end

  // Pacer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q    <= '0;
      active_q   <= 1'b0;
      tx_send_q  <= 1'b0;
      gap_done_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      active_q   <= active_d;
      tx_send_q  <= tx_send_d;
      gap_done_q <= gap_done_d;
    end
  end

  assign tx_send  = tx_send_q;
  assign gap_done = gap_done_q;

endmodule

// File: rtl/telemetry_framer.sv
// Collects 32-bit words into a frame (sync, len, payload, xor) and paces bytes to a UART.
module telemetry_framer
  import ice_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 139,
  parameter int unsigned BYTE_GAP_CLKS  = 1529,
  parameter int unsigned SEND_HIGH_CLKS = 2,
  parameter int unsigned MAX_WORDS      = 8,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  input  logic        word_last,
  output logic        word_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_send,
  output logic        busy,
  output logic        overflow
);

  // Never pace faster than one UART character, even if misconfigured.
  localparam int unsigned CHAR_CLKS = 10 * CLKS_PER_BIT;
  localparam int unsigned GAP_CLKS  = (BYTE_GAP_CLKS > CHAR_CLKS) ? BYTE_GAP_CLKS : CHAR_CLKS + 1;
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int unsigned WIDX_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  fr_state_e          state_q, state_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic [7:0]         chk_q, chk_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               word_ready_q, word_ready_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        word_buf_q [MAX_WORDS];

  logic               accept_c, at_max_c, close_c, last_byte_c;
  logic               start_c, pacer_send_c, gap_done_c;
  logic [LEN_W-1:0]   len_c;
  logic [IDX_W-1:0]   off_c;
  logic [WIDX_W-1:0]  widx_c;
  logic [31:0]        sel_word_c;
  logic [7:0]         payload_c, byte_mux_c;

  assign accept_c    = word_valid && word_ready_q;
  assign at_max_c    = (word_count_q == CNT_W'(MAX_WORDS - 1));
  assign close_c     = accept_c && (word_last || at_max_c);
  assign len_c       = LEN_W'(word_count_q) << 2;
  assign last_byte_c = (idx_q == (IDX_W'(len_c) + IDX_W'(2)));
  assign off_c       = idx_q - IDX_W'(2);
  assign widx_c      = off_c[WIDX_W+1:2];
  assign sel_word_c  = word_buf_q[widx_c];
  assign start_c     = (state_q == LOAD);

  // Payload byte select, MSB first within each word
  always_comb begin
    payload_c = 8'h00;
    case (off_c[1:0])
      2'd0: payload_c = sel_word_c[31:24];
      2'd1: payload_c = sel_word_c[23:16];
      2'd2: payload_c = sel_word_c[15:8];
      default: payload_c = sel_word_c[7:0];
    endcase
  end

  // Frame byte for the current index
  always_comb begin
    if (idx_q == IDX_W'(0))      byte_mux_c = SYNC_BYTE;
    else if (idx_q == IDX_W'(1)) byte_mux_c = len_c;
    else if (last_byte_c)        byte_mux_c = chk_q ^ len_c;
    else                         byte_mux_c = payload_c;
  end

  frame_byte_pacer #(
    .BYTE_GAP_CLKS  (GAP_CLKS),
    .SEND_HIGH_CLKS (SEND_HIGH_CLKS)
  ) u_pacer (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start_c),
    .tx_send  (pacer_send_c),
    .gap_done (gap_done_c)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= COLLECT;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (close_c) state_d = LOAD;
      LOAD:    state_d = PULSE;
      PULSE:   if (pacer_send_c) state_d = GAP;
      GAP:     if (gap_done_c) state_d = last_byte_c ? COLLECT : LOAD;
      default: state_d = COLLECT;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    word_count_d = word_count_q;
    chk_d        = chk_q;
    idx_d        = idx_q;
    tx_byte_d    = tx_byte_q;
    overflow_d   = 1'b0;
    word_ready_d = (state_d == COLLECT);
    busy_d       = (state_d != COLLECT);
    if (accept_c) begin
      word_count_d = word_count_q + CNT_W'(1);
      chk_d        = chk_q ^ word_in[31:24] ^ word_in[23:16] ^ word_in[15:8] ^ word_in[7:0];
      overflow_d   = at_max_c && !word_last;
    end
    if (state_q == LOAD) tx_byte_d = byte_mux_c;
    if (state_q == GAP && gap_done_c) begin
      if (last_byte_c) begin
        word_count_d = '0;
        chk_d        = 8'h00;
        idx_d        = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_count_q <= '0;
      chk_q        <= 8'h00;
      idx_q        <= '0;
      tx_byte_q    <= 8'h00;
      word_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      word_count_q <= word_count_d;
      chk_q        <= chk_d;
      idx_q        <= idx_d;
      tx_byte_q    <= tx_byte_d;
      word_ready_q <= word_ready_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  // Word buffer; stale contents are never read since word_count gates the frame
  always_ff @(posedge clock) begin
    if (accept_c) word_buf_q[word_count_q[WIDX_W-1:0]] <= word_in;
  end

  assign word_ready = word_ready_q;
  assign tx_byte    = tx_byte_q;
  assign tx_send    = pacer_send_c;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: two instances (MAX_WORDS 8 and 2), muxed by sel.
module tb_telemetry_framer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] word_in = 32'h0;
  logic        word_valid = 1'b0;
  logic        word_last = 1'b0;
  logic        sel = 1'b0;

  logic        ready_a, send_a, busy_a, ovf_a;
  logic        ready_b, send_b, busy_b, ovf_b;
  logic [7:0]  byte_a, byte_b;
  logic        valid_a, valid_b;

  logic        ready_m, send_m, busy_m, ovf_m;
  logic [7:0]  byte_m;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          ovf_cnt = 0;
  logic        send_prev = 1'b0;
  logic [7:0]  cap_byte [$];
  int          cap_cyc [$];

  always #5 clk = ~clk;

  assign valid_a = word_valid & ~sel;
  assign valid_b = word_valid & sel;
  assign ready_m = sel ? ready_b : ready_a;
  assign send_m  = sel ? send_b  : send_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign ovf_m   = sel ? ovf_b   : ovf_a;
  assign byte_m  = sel ? byte_b  : byte_a;

  telemetry_framer #(.CLKS_PER_BIT(1), .BYTE_GAP_CLKS(20), .SEND_HIGH_CLKS(2), .MAX_WORDS(8)) dut_a (
    .clock(clk), .reset_n(reset_n), .word_in(word_in), .word_valid(valid_a), .word_last(word_last),
    .word_ready(ready_a), .tx_byte(byte_a), .tx_send(send_a), .busy(busy_a), .overflow(ovf_a));

  telemetry_framer #(.CLKS_PER_BIT(1), .BYTE_GAP_CLKS(20), .SEND_HIGH_CLKS(2), .MAX_WORDS(2)) dut_b (
    .clock(clk), .reset_n(reset_n), .word_in(word_in), .word_valid(valid_b), .word_last(word_last),
    .word_ready(ready_b), .tx_byte(byte_b), .tx_send(send_b), .busy(busy_b), .overflow(ovf_b));

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every tx_send rising edge with its byte and cycle
  always @(negedge clk) begin
    if (send_m && !send_prev) begin
      cap_byte.push_back(byte_m);
      cap_cyc.push_back(cyc);
    end
    send_prev <= send_m;
    if (ovf_m) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic push_word(input logic [31:0] w, input logic l, output int acc, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    acc = -1;
    @(negedge clk);
    word_in = w; word_valid = 1'b1; word_last = l;
    while (ready_m !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      ok = 1'b0;
      word_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    #1;
    word_valid = 1'b0; word_last = 1'b0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    int k;
    k = 0;
    while (cap_byte.size() < n && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    ok = (cap_byte.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int k;
    k = 0;
    while (busy_m && k < 3000) begin
      @(negedge clk);
      k++;
    end
    ok = !busy_m;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (ready_m !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_m); end
    checks++; if (byte_m !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", byte_m); end
    checks++; if (send_m !== 1'b0) begin failures++; $display("FAIL reset_send got=%b exp=0", send_m); end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_m); end
    checks++; if (ovf_m !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_m); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp [7] = '{8'hA5, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0C};
    int base, acc, k, busy_low;
    bit ok;
    base = cap_byte.size();
    push_word(32'h12345678, 1'b1, acc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_accept got=timeout exp=accepted"); return; end
    @(negedge clk);
    checks++; if (ready_m !== 1'b0) begin failures++; $display("FAIL single_ready_low got=%b exp=0", ready_m); end
    checks++; if (busy_m !== 1'b1) begin failures++; $display("FAIL single_busy_load got=%b exp=1", busy_m); end
    @(negedge clk);
    checks++; if (byte_m !== 8'hA5 || send_m !== 1'b0) begin failures++; $display("FAIL single_t2 got=%h/%b exp=a5/0", byte_m, send_m); end
    @(negedge clk);
    checks++; if (send_m !== 1'b1) begin failures++; $display("FAIL single_t3_send got=%b exp=1", send_m); end
    busy_low = 0; k = 0;
    while (cap_byte.size() < base + 7 && k < 3000) begin
      @(negedge clk); #1; k++;
      if (!busy_m) busy_low++;
    end
    checks++; if (cap_byte.size() < base + 7) begin failures++; $display("FAIL single_bytes got=%0d exp=7", cap_byte.size() - base); return; end
    checks++; if (busy_low != 0) begin failures++; $display("FAIL single_busy got=%0d_low_cycles exp=0", busy_low); end
    checks++; if (cap_cyc[base] != acc + 3) begin failures++; $display("FAIL single_first_edge got=%0d exp=%0d", cap_cyc[base], acc + 3); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (cap_byte[base+i] !== exp[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, cap_byte[base+i], exp[i]); end
    end
    for (int i = 1; i < 7; i++) begin
      checks++; if (cap_cyc[base+i] - cap_cyc[base+i-1] != 21) begin failures++; $display("FAIL single_gap%0d got=%0d exp=21", i, cap_cyc[base+i] - cap_cyc[base+i-1]); end
    end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle got=busy exp=idle"); end
  endtask

  task automatic test_two_words();
    logic [7:0] exp [11] = '{8'hA5, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2B};
    int base, acc;
    bit ok;
    base = cap_byte.size();
    push_word(32'hDEADBEEF, 1'b0, acc, ok);
    push_word(32'h00000001, 1'b1, acc, ok);
    wait_bytes(base + 11, ok);
    checks++; if (!ok) begin failures++; $display("FAIL two_bytes got=%0d exp=11", cap_byte.size() - base); return; end
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_byte[base+i] !== exp[i]) begin failures++; $display("FAIL two_byte%0d got=%h exp=%h", i, cap_byte[base+i], exp[i]); end
    end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [14] = '{8'hA5, 8'h04, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hCD,
                             8'hA5, 8'h04, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h04};
    int base, acc, acc2;
    bit ok;
    base = cap_byte.size();
    push_word(32'hCAFEF00D, 1'b1, acc, ok);
    push_word(32'h0000FFFF, 1'b1, acc2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_held_accept got=timeout exp=accepted"); return; end
    wait_bytes(base + 14, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_bytes got=%0d exp=14", cap_byte.size() - base); return; end
    checks++; if (acc2 - cap_cyc[base+6] != 19) begin failures++; $display("FAIL b2b_accept_time got=%0d exp=19", acc2 - cap_cyc[base+6]); end
    checks++; if (cap_cyc[base+7] - cap_cyc[base+6] < 20) begin failures++; $display("FAIL b2b_sync_spacing got=%0d exp>=20", cap_cyc[base+7] - cap_cyc[base+6]); end
    for (int i = 0; i < 14; i++) begin
      checks++; if (cap_byte[base+i] !== exp[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, cap_byte[base+i], exp[i]); end
    end
    wait_idle(ok);
    repeat (60) @(negedge clk);
    checks++; if (cap_byte.size() != base + 14) begin failures++; $display("FAIL b2b_no_dup got=%0d exp=14", cap_byte.size() - base); end
  endtask

  task automatic test_toggle_valid();
    logic [7:0] exp [15] = '{8'hA5, 8'h0C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h04, 8'h08};
    int base, acc;
    bit ok;
    base = cap_byte.size();
    push_word(32'h01000000, 1'b0, acc, ok);
    @(negedge clk);
    push_word(32'h00020000, 1'b0, acc, ok);
    @(negedge clk);
    push_word(32'h00000304, 1'b1, acc, ok);
    wait_bytes(base + 15, ok);
    checks++; if (!ok) begin failures++; $display("FAIL toggle_bytes got=%0d exp=15", cap_byte.size() - base); return; end
    for (int i = 0; i < 15; i++) begin
      checks++; if (cap_byte[base+i] !== exp[i]) begin failures++; $display("FAIL toggle_byte%0d got=%h exp=%h", i, cap_byte[base+i], exp[i]); end
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp [7] = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFB};
    int base, acc;
    bit ok;
    base = cap_byte.size();
    push_word(32'h11111111, 1'b0, acc, ok);
    push_word(32'h22222222, 1'b1, acc, ok);
    wait_bytes(base + 5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_pre_bytes got=%0d exp=5", cap_byte.size() - base); return; end
    reset_n = 1'b0;
    #1;
    checks++; if (send_m !== 1'b0) begin failures++; $display("FAIL rst_send got=%b exp=0", send_m); end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_m); end
    checks++; if (ready_m !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready_m); end
    checks++; if (byte_m !== 8'h00) begin failures++; $display("FAIL rst_byte got=%h exp=00", byte_m); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    base = cap_byte.size();
    push_word(32'h000000FF, 1'b1, acc, ok);
    wait_bytes(base + 7, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_post_bytes got=%0d exp=7", cap_byte.size() - base); return; end
    for (int i = 0; i < 7; i++) begin
      checks++; if (cap_byte[base+i] !== exp[i]) begin failures++; $display("FAIL rst_byte%0d got=%h exp=%h", i, cap_byte[base+i], exp[i]); end
    end
    wait_idle(ok);
  endtask

  task automatic test_overflow();
    logic [7:0] exp [22] = '{8'hA5, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00,
                             8'hA5, 8'h08, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h08};
    int base, acc, acc2, ov0;
    bit ok;
    sel = 1'b1;
    @(negedge clk);
    base = cap_byte.size();
    ov0 = ovf_cnt;
    push_word(32'h01020304, 1'b0, acc, ok);
    push_word(32'h05060708, 1'b0, acc, ok);
    push_word(32'h0A0B0C0D, 1'b0, acc2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_held_accept got=timeout exp=accepted"); return; end
    checks++; if (ovf_cnt - ov0 != 1) begin failures++; $display("FAIL ovf_pulse_count got=%0d exp=1", ovf_cnt - ov0); end
    push_word(32'h0E0F1011, 1'b1, acc, ok);
    wait_bytes(base + 22, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_bytes got=%0d exp=22", cap_byte.size() - base); return; end
    checks++; if (acc2 - cap_cyc[base+10] != 19) begin failures++; $display("FAIL ovf_held_time got=%0d exp=19", acc2 - cap_cyc[base+10]); end
    for (int i = 0; i < 22; i++) begin
      checks++; if (cap_byte[base+i] !== exp[i]) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, cap_byte[base+i], exp[i]); end
    end
    wait_idle(ok);
    checks++; if (ovf_cnt - ov0 != 1) begin failures++; $display("FAIL ovf_last_at_max got=%0d exp=1", ovf_cnt - ov0); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_single_word();
    test_two_words();
    test_back_to_back();
    test_toggle_valid();
    test_reset_mid_frame();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
